// File: rtl/npc_pkg.sv
// npc_pkg: shared state encoding, trap-cause codes and constants for the
// NPC multi-cycle sequencer.
package npc_pkg;

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_MEM_REQ    = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_WB         = 3'd5,
        S_TRAP       = 3'd6,
        S_HALT       = 3'd7
    } state_t;

    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_IFAULT    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LFAULT    = 4'd5;
    localparam logic [3:0] CAUSE_SFAULT    = 4'd7;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/npc_wait_timer.sv
// npc_wait_timer: counts cycles spent waiting for a memory response and
// flags the cycle in which the TIMEOUT-th wait cycle elapses.
// TIMEOUT = 0 disables the flag entirely.
module npc_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt;

    // Held at zero outside a wait state, so each wait starts counting from zero
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds completed wait cycles; the current one makes cnt + 1
    always_comb begin
        expired = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) >= TIMEOUT);
    end

endmodule

// File: rtl/npc_multicycle_ctrl.sv
// npc_multicycle_ctrl: multi-cycle fetch/execute/memory/write-back sequencer
// for the NPC core. Owns PC and instruction registers, issues valid/ready
// requests to instruction and data memory, and sequences traps and halt.
// Optional macro NPC_PERF_CNT_EN adds perf_cycle / perf_instret counters.
module npc_multicycle_ctrl
    import npc_pkg::*;
#(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned         TIMEOUT  = 255
`ifdef NPC_PERF_CNT_EN
    , parameter int unsigned       CNT_W    = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic             ifu_rsp_err,
    input  logic [31:0]      ifu_rsp_data,
    output logic             lsu_req_valid,
    output logic             lsu_req_wen,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    input  logic [XLEN-1:0]  lsu_rsp_data,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_reg_wr,
    input  logic             dec_csr_wr,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    input  logic [XLEN-1:0]  next_pc,
    input  logic [XLEN-1:0]  mtvec,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  mem_rdata,
    output logic             reg_wen,
    output logic             csr_wen,
    output logic             trap_valid,
    output logic [3:0]       trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic             halted
`ifdef NPC_PERF_CNT_EN
    , output logic [CNT_W-1:0] perf_cycle
    , output logic [CNT_W-1:0] perf_instret
`endif
);

    state_t     state;
    logic       in_wait;
    logic       tmo;
    logic       misaligned;
    logic [3:0] mem_cause;

    npc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (in_wait),
        .expired (tmo)
    );

    // Request, strobe and status outputs decoded from the registered state
    always_comb begin
        ifu_req_valid = (state == S_FETCH_REQ);
        ifu_addr      = pc;
        lsu_req_valid = (state == S_MEM_REQ);
        lsu_req_wen   = (state == S_MEM_REQ) && dec_mem_wr;
        misaligned    = (next_pc[1:0] != 2'b00);
        reg_wen       = (state == S_WB) && !misaligned && dec_reg_wr;
        csr_wen       = (state == S_WB) && !misaligned && dec_csr_wr;
        trap_valid    = (state == S_TRAP);
        halted        = (state == S_HALT);
        in_wait       = (state == S_FETCH_WAIT) || (state == S_MEM_WAIT);
        mem_cause     = dec_mem_wr ? CAUSE_SFAULT : CAUSE_LFAULT;
    end

    // Sequencer: state, PC, held instruction, load data and trap record
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH_REQ;
            pc         <= RESET_PC;
            inst       <= NOP;
            mem_rdata  <= '0;
            trap_cause <= '0;
            trap_epc   <= '0;
        end else begin
            case (state)
                S_FETCH_REQ: begin
                    if (ifu_req_ready) state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    // A response in the timeout cycle still wins over the timeout
                    if (ifu_rsp_valid && !ifu_rsp_err) begin
                        inst  <= ifu_rsp_data;
                        state <= S_EXEC;
                    end else if (ifu_rsp_valid || tmo) begin
                        trap_cause <= CAUSE_IFAULT;
                        trap_epc   <= pc;
                        state      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (dec_illegal) begin
                        trap_cause <= CAUSE_ILLEGAL;
                        trap_epc   <= pc;
                        state      <= S_TRAP;
                    end else if (dec_ebreak) begin
                        state <= S_HALT;
                    end else if (dec_mem_rd || dec_mem_wr) begin
                        state <= S_MEM_REQ;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM_REQ: begin
                    if (lsu_req_ready) state <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (lsu_rsp_valid && !lsu_rsp_err) begin
                        if (!dec_mem_wr) mem_rdata <= lsu_rsp_data;
                        state <= S_WB;
                    end else if (lsu_rsp_valid || tmo) begin
                        trap_cause <= mem_cause;
                        trap_epc   <= pc;
                        state      <= S_TRAP;
                    end
                end
                S_WB: begin
                    if (misaligned) begin
                        trap_cause <= CAUSE_IMISALIGN;
                        trap_epc   <= pc;
                        state      <= S_TRAP;
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH_REQ;
                    end
                end
                S_TRAP: begin
                    pc    <= mtvec;
                    state <= S_FETCH_REQ;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH_REQ;
                end
            endcase
        end
    end

`ifdef NPC_PERF_CNT_EN
    // Free-running cycle count (frozen in halt) and retired-instruction count
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (!halted) perf_cycle <= perf_cycle + 1'b1;
            if ((state == S_WB) && !misaligned) perf_instret <= perf_instret + 1'b1;
        end
    end
`endif

endmodule

// File: doc/npc_multicycle_ctrl.md
Name: npc_multicycle_ctrl

Overview:
Multi-cycle sequencer for the next-generation NPC core. It replaces the single-cycle "fetch, execute and write back in one clock" assumption with a state machine that talks to the instruction memory and data memory over valid/ready request channels and valid response channels. It owns the PC and instruction registers, produces one-cycle architectural-commit strobes for the existing datapath (decoder, register file, CSR file, ALU), and sequences traps and halt.

Parameters:
XLEN, 32, datapath and address width.
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum wait cycles for a memory response; 0 disables the timeout.
CNT_W, 64, performance-counter width (used only with NPC_PERF_CNT_EN).

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_addr  out  XLEN  fetch address (= pc)
ifu_rsp_valid  in  1  fetch response valid
ifu_rsp_err  in  1  fetch access fault
ifu_rsp_data  in  32  fetched instruction
lsu_req_valid  out  1  data request valid
lsu_req_wen  out  1  1 = store, 0 = load
lsu_req_ready  in  1  data request accepted
lsu_rsp_valid  in  1  data response valid
lsu_rsp_err  in  1  data access fault
lsu_rsp_data  in  XLEN  load data
dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_csr_wr, dec_ebreak, dec_illegal  in  1 each  decoder flags for the held inst
next_pc  in  XLEN  datapath-computed next PC
mtvec  in  XLEN  trap vector
pc  out  XLEN  architectural PC
inst  out  32  held instruction
mem_rdata  out  XLEN  latched load data
reg_wen  out  1  register-file write strobe
csr_wen  out  1  CSR write strobe
trap_valid  out  1  trap pulse
trap_cause  out  4  trap cause code
trap_epc  out  XLEN  faulting PC
halted  out  1  core halted

Behaviour:
- Reset values:
  - pc = RESET_PC; inst = 32'h0000_0013; mem_rdata = 0.
  - All valid outputs and strobes = 0; trap_cause = 0; trap_epc = 0; halted = 0.
  - State = FETCH_REQ.
- Reset is synchronous, active-high, and wins over every other event in the same cycle.
- Reset mid-transaction abandons the transaction. Memory slaves share rst, so no stale responses arrive afterwards.
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP, HALT.
- FETCH_REQ:
  - ifu_req_valid = 1 and ifu_addr = pc, held stable until accepted.
  - ifu_req_ready = 1 moves to FETCH_WAIT.
- FETCH_WAIT:
  - ifu_rsp_valid with err = 1 goes to TRAP with cause 1.
  - ifu_rsp_valid with err = 0 latches inst <= ifu_rsp_data and goes to EXEC.
  - Responses are sampled only in WAIT states and ignored in every other state.
- EXEC: lasts exactly one cycle. Priority order:
  1. dec_illegal: TRAP, cause 2.
  2. dec_ebreak: HALT.
  3. dec_mem_rd or dec_mem_wr: MEM_REQ.
  4. Otherwise: WB.
- MEM_REQ:
  - lsu_req_valid = 1 and lsu_req_wen = dec_mem_wr.
  - lsu_req_ready = 1 moves to MEM_WAIT.
- MEM_WAIT:
  - err = 1 goes to TRAP with cause 5 (load) or 7 (store).
  - Otherwise a load latches mem_rdata <= lsu_rsp_data and the state goes to WB.
- WB:
  - If next_pc[1:0] != 0: TRAP with cause 0; no writes; pc unchanged.
  - Otherwise: reg_wen = dec_reg_wr and csr_wen = dec_csr_wr for exactly this one cycle; pc <= next_pc; go to FETCH_REQ.
- TRAP:
  - trap_valid = 1 for one cycle; trap_cause and trap_epc = pc are registered and hold until the next trap.
  - pc <= mtvec; go to FETCH_REQ.
  - reg_wen = 0 and csr_wen = 0.
- HALT: halted = 1; absorbing until rst. No requests are issued.
- Timeout:
  - The wait counter clears on entry to any WAIT state.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without a response, go to TRAP with the same cause as an error response.
  - A response arriving in the same cycle the counter reaches TIMEOUT takes priority over the timeout.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load or store: 6 cycles.
- Strobes (reg_wen, csr_wen, trap_valid) are never asserted in two consecutive cycles.

Optional Feature:
NPC_PERF_CNT_EN
- Defined: adds outputs perf_cycle [CNT_W] and perf_instret [CNT_W], both reset to 0.
  - perf_cycle increments every cycle while not halted.
  - perf_instret increments on each successful WB.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package npc_pkg holds:
  - the state enum (3-bit encoding);
  - trap-cause constants: CAUSE_IMISALIGN = 0, CAUSE_IFAULT = 1, CAUSE_ILLEGAL = 2, CAUSE_LFAULT = 5, CAUSE_SFAULT = 7;
  - the NOP constant 32'h0000_0013.
- One sub-module, npc_wait_timer: the wait counter with timeout flag, instantiated once.

Test Plan:
- Zero-wait memory, ADDI at 0x8000_0000 with next_pc = 0x8000_0004: reg_wen pulses in cycle 4 only; pc = 0x8000_0004 in cycle 5.
- Load with ifu_req_ready delayed 3 cycles and lsu_rsp delayed 2 cycles: ifu_addr stays stable while waiting; mem_rdata = lsu_rsp_data; reg_wen pulses once; total 11 cycles.
- Fetch with ifu_rsp_err = 1 at pc = 0x8000_0010, mtvec = 0x8000_0100: trap_valid pulses once, trap_cause = 1, trap_epc = 0x8000_0010, next ifu_addr = 0x8000_0100, no reg_wen.
- TIMEOUT = 4 and a store with no lsu_rsp: TRAP with cause 7 after exactly 4 MEM_WAIT cycles; a response arriving at cycle 4 goes to WB instead.
- WB with next_pc = 0x8000_0006: TRAP with cause 0, pc stays at its old value, no reg_wen or csr_wen.
- EBREAK: halted = 1 permanently and no further requests; rst asserted mid-FETCH_WAIT in a separate run returns all outputs to their reset values the next cycle and fetch restarts at RESET_PC.
